alu_req_arbiter: RTL
====================

Name: alu_req_arbiter

Overview:
Shares one combinational 32-bit ALU (3-bit op; result y; flags z, n, c, v) among NUM_REQ requesters. Round-robin arbitration over valid/ready request channels, a registered issue stage driving the ALU, and a registered response stage returning result, flags and requester ID. Sits between the execution clients and the single ALU instance; the ALU itself is external and connected through the alu_* ports.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH, 32, operand/result width; matches ALU
ID_W, 2, width of rsp_id; must be >= clog2(NUM_REQ)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle
req_op  in  3*NUM_REQ  packed ops; requester i at [3i+2:3i]
req_a  in  WIDTH*NUM_REQ  packed operand A
req_b  in  WIDTH*NUM_REQ  packed operand B
alu_op  out  3  op to ALU
alu_a  out  WIDTH  operand A to ALU
alu_b  out  WIDTH  operand B to ALU
alu_y  in  WIDTH  ALU result
alu_flags  in  4  {z,n,c,v} from ALU
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_id  out  ID_W  index of requester that issued the op
rsp_y  out  WIDTH  registered result
rsp_flags  out  4  registered {z,n,c,v}
rsp_err  out  1  illegal-op marker (see Optional Feature)

Behaviour:
- Reset (async, rst_n low): req_ready=0, issue stage empty, alu_op/alu_a/alu_b=0, rsp_valid=0, rsp_id=0, rsp_y=0, rsp_flags=0, rsp_err=0, RR pointer=0 (requester 0 highest priority after reset). Reset mid-transaction drops all in-flight ops; no response emitted.
- Handshake: transfer on valid&&ready, same edge. Requesters hold valid/op/a/b stable until accepted. rsp_* stable while rsp_valid && !rsp_ready.
- Arbitration: combinational. Search from requester (ptr) upward with wrap NUM_REQ-1 -> 0; first with req_valid wins. req_ready[winner]=1 only if can_accept. On accept, ptr <= winner+1 (wraps to 0). No accept -> ptr unchanged.
- Stages: ISSUE register {valid, id, op, a, b} drives alu_* directly; RSP register {valid, id, y, flags, err}.
- can_accept = !issue_valid || issue_moves; issue_moves = issue_valid && (!rsp_valid || rsp_ready).
- On issue_moves: RSP captures {issue_id, alu_y, alu_flags}; rsp_valid<=1. If rsp_valid&&rsp_ready and no issue_moves: rsp_valid<=0.
- Latency: accept at edge N -> rsp_valid at edge N+1 (visible cycle after next), i.e. 2 edges accept-to-response capture, 1 cycle min ALU-to-response.
- Throughput: 1 op/cycle with rsp_ready held high.
- Full: issue and rsp both valid and rsp_ready=0 -> all req_ready=0; no state changes; alu_* hold.
- Simultaneous rsp drain + issue move + new accept: all three occur on same edge.
- alu_* hold last issued values when issue stage empties (not zeroed).
- Single requester continuously valid with others idle: granted every cycle. All valid: grant sequence 0,1,2,3,0,...

Optional Feature:
ALU_ARB_OPCHECK_EN
- Defined: ops 6 and 7 are illegal. Still accepted and occupy issue/rsp slots in order, but alu_op driven 0, alu_a/alu_b 0; response returns rsp_y=0, rsp_flags=0, rsp_err=1 with correct rsp_id.
- Undefined: no check; all 8 ops forwarded verbatim; rsp_err tied 0.

Test Plan:
- Reset then single request: req0 op=0 a=2 b=3, rsp_ready=1 -> rsp_valid 2 edges after accept, rsp_id=0, rsp_y=5, rsp_flags=4'b0000.
- All 4 requesters valid continuously, op=1 a=7 b=7 -> grants 0,1,2,3,0 in consecutive cycles; every response y=0, z=1; rsp_id 0,1,2,3,0.
- Backpressure: rsp_ready=0 for 5 cycles while req1 valid -> exactly 2 ops accepted, then req_ready=0; rsp_* stable; release -> responses in order, no loss or duplicate.
- SLT: req2 op=5 a=32'hFFFF_FFFF b=1 -> rsp_y=1, rsp_id=2.
- rst_n asserted with issue and rsp full -> all outputs 0 immediately (async); after release first grant to requester 0.
- With ALU_ARB_OPCHECK_EN: req3 op=7 a=5 b=5 -> rsp_err=1, rsp_y=0, rsp_id=3; without macro op=7 forwarded on alu_op, rsp_err=0.

Source files
------------

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one external ALU among NUM_REQ requesters.
// Optional illegal-op screening (ops 6/7) is built when ALU_ARB_OPCHECK_EN is defined.
module alu_req_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int ID_W    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [3*NUM_REQ-1:0]   req_op,
    input  logic [WIDTH*NUM_REQ-1:0] req_a,
    input  logic [WIDTH*NUM_REQ-1:0] req_b,
    output logic [2:0]             alu_op,
    output logic [WIDTH-1:0]       alu_a,
    output logic [WIDTH-1:0]       alu_b,
    input  logic [WIDTH-1:0]       alu_y,
    input  logic [3:0]             alu_flags,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [WIDTH-1:0]       rsp_y,
    output logic [3:0]             rsp_flags,
    output logic                   rsp_err
);

    logic [ID_W-1:0]  ptr;
    logic             iss_v;
    logic [ID_W-1:0]  iss_id;
    logic [2:0]       iss_op;
    logic [WIDTH-1:0] iss_a;
    logic [WIDTH-1:0] iss_b;
    logic             iss_err;

    logic             issue_moves;
    logic             can_accept;
    logic             found;
    logic [ID_W-1:0]  win;
    int               j;
    logic             accept;
    logic [2:0]       win_op;
    logic [WIDTH-1:0] win_a;
    logic [WIDTH-1:0] win_b;
    logic             illegal;

    assign issue_moves = iss_v && (!rsp_valid || rsp_ready);
    assign can_accept  = !iss_v || issue_moves;

    // Search upward from ptr with wrap; first valid requester wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        j     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_REQ)
                j = j - NUM_REQ;
            if (!found && req_valid[j]) begin
                found = 1'b1;
                win   = ID_W'(j);
            end
        end
    end

    assign accept    = found && can_accept && rst_n;
    assign req_ready = accept ? (NUM_REQ'(1) << win) : '0;

    assign win_op = req_op[int'(win)*3 +: 3];
    assign win_a  = req_a[int'(win)*WIDTH +: WIDTH];
    assign win_b  = req_b[int'(win)*WIDTH +: WIDTH];

`ifdef ALU_ARB_OPCHECK_EN
    assign illegal = win_op[2] & win_op[1];
`else
    assign illegal = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr     <= '0;
            iss_v   <= 1'b0;
            iss_id  <= '0;
            iss_op  <= '0;
            iss_a   <= '0;
            iss_b   <= '0;
            iss_err <= 1'b0;
        end else if (accept) begin
            iss_v   <= 1'b1;
            iss_id  <= win;
            iss_op  <= illegal ? 3'd0 : win_op;
            iss_a   <= illegal ? '0 : win_a;
            iss_b   <= illegal ? '0 : win_b;
            iss_err <= illegal;
            ptr     <= (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
        end else if (issue_moves) begin
            // Operands stay on the ALU bus after the slot empties.
            iss_v <= 1'b0;
        end
    end

    assign alu_op = iss_op;
    assign alu_a  = iss_a;
    assign alu_b  = iss_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_y     <= '0;
            rsp_flags <= '0;
            rsp_err   <= 1'b0;
        end else if (issue_moves) begin
            rsp_valid <= 1'b1;
            rsp_id    <= iss_id;
            rsp_y     <= iss_err ? '0 : alu_y;
            rsp_flags <= iss_err ? 4'd0 : alu_flags;
            rsp_err   <= iss_err;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule
